phase_timer: RTL and testbench

PHASE_TIMER -- requirements
Module: phase_timer

---
 rtl/phase_timer_if.sv | 30 +++
 rtl/phase_timer.sv | 121 ++++++++++++
 tb/tb_phase_timer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_timer_if.sv
// Control/status bundle for phase_timer. The controller drives the
// request and duration fields; the timer drives status and done pulses.
interface phase_timer_if #(
  parameter int NUM_PHASES = 3,
  parameter int CNT_W      = 28,
  parameter int PH_W       = $clog2(NUM_PHASES)
) ();

  logic                        start;
  logic                        abort;
  logic                        enable;
  logic                        loop;
  logic [NUM_PHASES*CNT_W-1:0] dur;
  logic                        busy;
  logic [PH_W-1:0]             phase;
  logic [CNT_W-1:0]            remaining;
  logic                        phase_done;
  logic                        seq_done;

  modport master (
    output start, abort, enable, loop, dur,
    input  busy, phase, remaining, phase_done, seq_done
  );

  modport slave (
    input  start, abort, enable, loop, dur,
    output busy, phase, remaining, phase_done, seq_done
  );

endinterface

// File: rtl/phase_timer.sv
// Sequencer that walks through NUM_PHASES timed phases. Each phase k lasts
// dur[k]+1 enabled cycles; the duration is latched on phase entry so the
// controller may rewrite dur while a phase is running. Done pulses are
// registered and appear in the first cycle of the following phase.
module phase_timer #(
  parameter int NUM_PHASES = 3,
  parameter int CNT_W      = 28,
  parameter int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic         clk,
  input  logic         rst_n,
  phase_timer_if.slave tmr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  state_t           state_reg, state_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic             phase_done_reg, phase_done_next;
  logic             seq_done_reg, seq_done_next;

  logic [CNT_W-1:0] dur_arr [NUM_PHASES];
  logic [PH_W-1:0]  phase_inc;

  // Unpack the flat duration bus into one entry per phase.
  for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_dur
    assign dur_arr[gi] = tmr.dur[gi*CNT_W +: CNT_W];
  end

  assign phase_inc = phase_reg + PH_W'(1);

  // State, counters and done pulses; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      rem_reg        <= '0;
      phase_done_reg <= 1'b0;
      seq_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      rem_reg        <= rem_next;
      phase_done_reg <= phase_done_next;
      seq_done_reg   <= seq_done_next;
    end
  end

  // Next-state logic: abort beats start, start beats expiry, and an
  // enabled cycle in PAUSE counts just like one in RUN so a pause delays
  // the schedule by exactly the number of disabled cycles.
  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    rem_next        = rem_reg;
    phase_done_next = 1'b0;
    seq_done_next   = 1'b0;

    if (tmr.abort) begin
      state_next = IDLE;
      phase_next = '0;
      rem_next   = '0;
    end else if (tmr.start) begin
      state_next = RUN;
      phase_next = '0;
      rem_next   = dur_arr[0];
    end else begin
      case (state_reg)
        IDLE: begin
          phase_next = '0;
          rem_next   = '0;
        end
        RUN, PAUSE: begin
          if (!tmr.enable) begin
            state_next = PAUSE;
          end else begin
            state_next = RUN;
            if (rem_reg != '0) begin
              rem_next = rem_reg - CNT_W'(1);
            end else begin
              phase_done_next = 1'b1;
              if (phase_reg == LAST_PH) begin
                seq_done_next = 1'b1;
                if (tmr.loop) begin
                  phase_next = '0;
                  rem_next   = dur_arr[0];
                end else begin
                  state_next = IDLE;
                  phase_next = '0;
                  rem_next   = '0;
                end
              end else begin
                phase_next = phase_inc;
                rem_next   = dur_arr[phase_inc];
              end
            end
          end
        end
        default: begin
          state_next = IDLE;
          phase_next = '0;
          rem_next   = '0;
        end
      endcase
    end
  end

  assign tmr.busy       = (state_reg != IDLE);
  assign tmr.phase      = phase_reg;
  assign tmr.remaining  = rem_reg;
  assign tmr.phase_done = phase_done_reg;
  assign tmr.seq_done   = seq_done_reg;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: every started sequence pushes the
// cycles at which done pulses are due; a negedge monitor pops and compares.
module tb_phase_timer;

  localparam int NP = 3;
  localparam int CW = 28;

  typedef struct {
    int cyc;
    bit seq;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  sb_q[$];

  phase_timer_if #(.NUM_PHASES(NP), .CNT_W(CW)) tmr ();

  phase_timer #(.NUM_PHASES(NP), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tmr  (tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input bit s);
    ev_t e;
    e.cyc = c;
    e.seq = s;
    sb_q.push_back(e);
  endtask

  task automatic set_dur(input int d0, input int d1, input int d2);
    tmr.dur = {CW'(d2), CW'(d1), CW'(d0)};
  endtask

  // Wait until the given cycle; always returns 1 time unit after an edge.
  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < target) chk("wait_timeout", cyc, target);
  endtask

  // Pulse start for one cycle; base is the first cycle spent in RUN.
  task automatic do_start(output int base);
    tmr.start = 1'b1;
    @(posedge clk);
    #1;
    tmr.start = 1'b0;
    base = cyc;
  endtask

  task automatic push_std(input int b);
    push_ev(b + 5, 1'b0);
    push_ev(b + 7, 1'b0);
    push_ev(b + 10, 1'b1);
  endtask

  // Done-pulse monitor: one line per observed pulse.
  always @(negedge clk) begin
    ev_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      chk("pd_missed_at", cyc, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (tmr.phase_done) begin
      if (sb_q.size() == 0) begin
        chk("pd_unexpected", tmr.phase_done, 0);
      end else begin
        e = sb_q.pop_front();
        $display("cycle %0d: phase_done seq_done=%0b (expected cycle %0d seq %0b)",
                 cyc, tmr.seq_done, e.cyc, e.seq);
        chk("pd_cycle", cyc, e.cyc);
        chk("sd_with_pd", tmr.seq_done, e.seq);
      end
    end else if (tmr.seq_done) begin
      chk("sd_alone", tmr.seq_done, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, b2, b3, b4;
    rst_n      = 1'b0;
    tmr.start  = 1'b0;
    tmr.abort  = 1'b0;
    tmr.enable = 1'b1;
    tmr.loop   = 1'b0;
    set_dur(4, 1, 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", tmr.busy, 0);
    chk("rst_phase", tmr.phase, 0);
    chk("rst_rem", tmr.remaining, 0);
    chk("rst_pd", tmr.phase_done, 0);
    chk("rst_sd", tmr.seq_done, 0);
    rst_n = 1'b1;
    wait_cyc(cyc + 3);
    chk("idle_busy", tmr.busy, 0);

    // Basic one-shot run; dur[0] rewritten mid-phase must not matter.
    do_start(b);
    $display("seq one-shot start at cycle %0d", b);
    push_std(b);
    chk("entry_phase", tmr.phase, 0);
    chk("entry_rem", tmr.remaining, 4);
    chk("entry_busy", tmr.busy, 1);
    wait_cyc(b + 2);
    set_dur(9, 1, 2);
    wait_cyc(b + 4);
    chk("p0_end_rem", tmr.remaining, 0);
    wait_cyc(b + 5);
    chk("p1_phase", tmr.phase, 1);
    chk("p1_rem", tmr.remaining, 1);
    set_dur(4, 1, 2);
    wait_cyc(b + 7);
    chk("p2_phase", tmr.phase, 2);
    chk("p2_rem", tmr.remaining, 2);
    wait_cyc(b + 10);
    chk("oneshot_busy_drop", tmr.busy, 0);
    wait_cyc(b + 13);
    chk("oneshot_idle_phase", tmr.phase, 0);

    // Looping run: wraps to phase 0 with dur[0], then stops on the 2nd lap.
    tmr.loop = 1'b1;
    do_start(b);
    $display("seq loop start at cycle %0d", b);
    push_std(b);
    push_std(b + 10);
    wait_cyc(b + 10);
    chk("wrap_phase", tmr.phase, 0);
    chk("wrap_rem", tmr.remaining, 4);
    chk("wrap_busy", tmr.busy, 1);
    wait_cyc(b + 11);
    tmr.loop = 1'b0;
    wait_cyc(b + 20);
    chk("loop_end_busy", tmr.busy, 0);
    wait_cyc(b + 23);

    // Pause for three cycles in phase 1: later pulses slip by three.
    do_start(b);
    $display("seq pause start at cycle %0d", b);
    push_ev(b + 5, 1'b0);
    push_ev(b + 10, 1'b0);
    push_ev(b + 13, 1'b1);
    wait_cyc(b + 5);
    tmr.enable = 1'b0;
    wait_cyc(b + 7);
    chk("pause_rem", tmr.remaining, 1);
    chk("pause_phase", tmr.phase, 1);
    chk("pause_busy", tmr.busy, 1);
    wait_cyc(b + 8);
    chk("pause_rem_end", tmr.remaining, 1);
    tmr.enable = 1'b1;
    wait_cyc(b + 16);

    // start+abort together in phase 2: idle, no pulse.
    do_start(b);
    $display("seq abort start at cycle %0d", b);
    push_ev(b + 5, 1'b0);
    push_ev(b + 7, 1'b0);
    wait_cyc(b + 8);
    tmr.start = 1'b1;
    tmr.abort = 1'b1;
    @(posedge clk);
    #1;
    tmr.start = 1'b0;
    tmr.abort = 1'b0;
    chk("abort_busy", tmr.busy, 0);
    chk("abort_phase", tmr.phase, 0);
    chk("abort_rem", tmr.remaining, 0);
    wait_cyc(b + 13);

    // start alone in phase 2, then start on the final expiry cycle.
    do_start(b2);
    push_ev(b2 + 5, 1'b0);
    push_ev(b2 + 7, 1'b0);
    wait_cyc(b2 + 8);
    do_start(b3);
    $display("seq restart at cycle %0d", b3);
    chk("restart_phase", tmr.phase, 0);
    chk("restart_rem", tmr.remaining, 4);
    push_ev(b3 + 5, 1'b0);
    push_ev(b3 + 7, 1'b0);
    wait_cyc(b3 + 9);
    chk("expiry_cycle_rem", tmr.remaining, 0);
    do_start(b4);
    $display("seq restart on expiry at cycle %0d", b4);
    chk("restart2_rem", tmr.remaining, 4);
    push_std(b4);
    wait_cyc(b4 + 13);

    // Asynchronous reset in phase 1, off the clock edge.
    do_start(b);
    $display("seq reset start at cycle %0d", b);
    push_ev(b + 5, 1'b0);
    wait_cyc(b + 6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", tmr.busy, 0);
    chk("arst_phase", tmr.phase, 0);
    chk("arst_rem", tmr.remaining, 0);
    chk("arst_pd", tmr.phase_done, 0);
    chk("arst_sd", tmr.seq_done, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_cyc(cyc + 3);
    chk("post_rst_idle", tmr.busy, 0);
    do_start(b);
    push_std(b);
    chk("post_rst_rem", tmr.remaining, 4);
    wait_cyc(b + 12);

    // All-zero durations: three back-to-back one-cycle phases.
    set_dur(0, 0, 0);
    do_start(b);
    $display("seq zero-dur start at cycle %0d", b);
    chk("zero_entry_rem", tmr.remaining, 0);
    chk("zero_entry_busy", tmr.busy, 1);
    push_ev(b + 1, 1'b0);
    push_ev(b + 2, 1'b0);
    push_ev(b + 3, 1'b1);
    wait_cyc(b + 2);
    chk("zero_p2_phase", tmr.phase, 2);
    wait_cyc(b + 5);
    chk("zero_end_busy", tmr.busy, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
